branch_resolve_predictor: RTL and testbench

- Front-end partner of the execute stage. Predicts direction and target for the fetch PC using a 2-bit BHT and a direct-mapped BTB.
- Consumes the execute stage's resolved branch_taken / branch_target and produces the registered mispredict_flush and redirect PC that execute and fetch consume.
- Closes the loop: execute resolves, this block judges the prediction, then trains and redirects.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/branch_resolve_predictor_if.sv | 40 ++++
 rtl/bp_btb.sv | 66 ++++++
 rtl/branch_resolve_predictor.sv | 126 ++++++++++++
 tb/tb_branch_resolve_predictor.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared encodings and sizing helpers for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // 2-bit direction counter encodings
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Every BHT counter leaves reset weakly not-taken
  localparam logic [1:0] BHT_RESET = WNT;

  // Sequential fall-through distance
  localparam int unsigned PC_INC = 4;

  // Index width of a power-of-two table addressed by word PC
  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Tag width left over once the index and byte offset are removed
  function automatic int unsigned tag_w(input int unsigned xlen, input int unsigned entries);
    return xlen - $clog2(entries) - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_predictor_if
// Description : Fetch / execute / redirect bundle between the pipeline and the
//               branch predictor. slave = predictor, master = pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic            ex_is_branch;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            mispredict_flush;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredicts;

  modport slave (
    input  fetch_pc, ex_valid, ex_is_branch, ex_pc, ex_pred_taken,
           ex_pred_target, branch_taken, branch_target,
    output pred_taken, pred_target, mispredict_flush, redirect_pc,
           perf_branches, perf_mispredicts
  );

  modport master (
    output fetch_pc, ex_valid, ex_is_branch, ex_pc, ex_pred_taken,
           ex_pred_target, branch_taken, branch_target,
    input  pred_taken, pred_target, mispredict_flush, redirect_pc,
           perf_branches, perf_mispredicts
  );
endinterface
`default_nettype wire

// File: rtl/bp_btb.sv
`default_nettype none
// ============================================================================
// Module      : bp_btb
// Description : Direct-mapped branch target buffer. Combinational read port,
//               registered write port; reads see pre-write contents.
//               Addressed by word PC (pc[XLEN-1:2]).
// Revision    : 1.0 - initial release
// ============================================================================
module bp_btb
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic [XLEN-3:0] rd_wpc,
  output logic                 rd_hit,
  output logic [XLEN-1:0]      rd_target,
  input  wire logic            wr_en,
  input  wire logic [XLEN-3:0] wr_wpc,
  input  wire logic [XLEN-1:0] wr_target
);

  localparam int IW = int'(idx_w(ENTRIES));
  localparam int TW = int'(tag_w(XLEN, ENTRIES));

  logic [ENTRIES-1:0] r_valid;
  logic [TW-1:0]      r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];

  logic [IW-1:0] w_rd_idx;
  logic [TW-1:0] w_rd_tag;
  logic [IW-1:0] w_wr_idx;
  logic [TW-1:0] w_wr_tag;

  assign w_rd_idx = rd_wpc[IW-1:0];
  assign w_rd_tag = rd_wpc[XLEN-3:IW];
  assign w_wr_idx = wr_wpc[IW-1:0];
  assign w_wr_tag = wr_wpc[XLEN-3:IW];

  // Lookup: hit needs a valid entry with a matching tag
  always_comb begin
    rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    rd_target = r_target[w_rd_idx];
  end

  // Valid bits are the only reset state; tags and targets are don't-care
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Tag/target storage written alongside the valid bit
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= wr_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_predictor
// Description : 2-bit BHT + direct-mapped BTB predictor that judges resolved
//               branches from execute, trains, and issues a registered
//               one-cycle mispredict flush with the redirect PC.
//               Optional macro BP_PERF_CNT_EN adds branch/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_predictor
  import bp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16
) (
  input wire logic               clk,
  input wire logic               rst,
  branch_resolve_predictor_if.slave bus
);

  localparam int BHT_IW = int'(idx_w(BHT_ENTRIES));

  logic [1:0]        r_bht [BHT_ENTRIES];
  logic              r_flush;
  logic [XLEN-1:0]   r_redirect;

  logic [BHT_IW-1:0] w_fetch_idx;
  logic [BHT_IW-1:0] w_ex_idx;
  logic              w_btb_hit;
  logic [XLEN-1:0]   w_btb_target;
  logic              w_pred_taken;
  logic              w_resolve;
  logic              w_mis;
  logic              w_btb_wr;

  assign w_fetch_idx = bus.fetch_pc[BHT_IW+1:2];
  assign w_ex_idx    = bus.ex_pc[BHT_IW+1:2];

  bp_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_wpc    (bus.fetch_pc[XLEN-1:2]),
    .rd_hit    (w_btb_hit),
    .rd_target (w_btb_target),
    .wr_en     (w_btb_wr),
    .wr_wpc    (bus.ex_pc[XLEN-1:2]),
    .wr_target (bus.branch_target)
  );

  // Zero-latency prediction for the fetch PC
  always_comb begin
    w_pred_taken    = w_btb_hit && r_bht[w_fetch_idx][1];
    bus.pred_taken  = w_pred_taken;
    bus.pred_target = w_pred_taken ? w_btb_target : bus.fetch_pc + XLEN'(PC_INC);
  end

  // Judge the EX branch; the instruction behind a flush is wrong-path
  always_comb begin
    w_resolve = bus.ex_valid && bus.ex_is_branch && !r_flush;
    w_mis     = w_resolve &&
                ((bus.ex_pred_taken != bus.branch_taken) ||
                 (bus.branch_taken && (bus.ex_pred_target != bus.branch_target)));
    w_btb_wr  = w_resolve && bus.branch_taken;
  end

  // Saturating direction counters trained on every resolve
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= BHT_RESET;
      end
    end else if (w_resolve) begin
      if (bus.branch_taken) begin
        if (r_bht[w_ex_idx] != ST) begin
          r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'd1;
        end
      end else if (r_bht[w_ex_idx] != SNT) begin
        r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'd1;
      end
    end
  end

  // One-cycle flush pulse; redirect PC refreshed on each resolve and held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush    <= 1'b0;
      r_redirect <= '0;
    end else begin
      r_flush <= w_mis;
      if (w_resolve) begin
        r_redirect <= bus.branch_taken ? bus.branch_target : bus.ex_pc + XLEN'(PC_INC);
      end
    end
  end

  assign bus.mispredict_flush = r_flush;
  assign bus.redirect_pc      = r_redirect;

`ifdef BP_PERF_CNT_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (w_resolve) r_perf_branches    <= r_perf_branches + 32'd1;
      if (w_mis)     r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
    end
  end

  assign bus.perf_branches    = r_perf_branches;
  assign bus.perf_mispredicts = r_perf_mispredicts;
`else
  assign bus.perf_branches    = 32'd0;
  assign bus.perf_mispredicts = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_predictor
// Description : Self-checking bench: directed scenarios with literal
//               expectations, then randomized traffic against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_predictor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  branch_resolve_predictor_if #(.XLEN(32)) bus ();

  branch_resolve_predictor #(
    .XLEN        (32),
    .BHT_ENTRIES (64),
    .BTB_ENTRIES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain tables indexed by PC arithmetic
  int          m_cnt   [64];
  bit          m_valid [16];
  logic [31:0] m_tagpc [16];
  logic [31:0] m_tgt   [16];
  bit          m_flush;
  logic [31:0] m_redir;
  logic [31:0] m_pb;
  logic [31:0] m_pm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_taken(input logic [31:0] pc);
    int b;
    int t;
    b = int'((pc >> 2) % 64);
    t = int'((pc >> 2) % 16);
    return m_valid[t] && ((m_tagpc[t] >> 6) == (pc >> 6)) && (m_cnt[b] >= 2);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc);
    if (model_taken(pc)) return m_tgt[int'((pc >> 2) % 16)];
    return pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_cnt[i] = 1;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_flush = 1'b0;
    m_redir = 32'd0;
    m_pb    = 32'd0;
    m_pm    = 32'd0;
  endtask

  // Compare process: checks every cycle, then advances the model
  always @(negedge clk) begin
    bit resolve;
    bit mis;
    int b;
    int t;
    if (rst) begin
      model_reset();
      chk("rst_flush", {31'd0, bus.mispredict_flush}, 32'd0);
      chk("rst_redirect", bus.redirect_pc, 32'd0);
    end else begin
      chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, model_taken(bus.fetch_pc)});
      chk("pred_target", bus.pred_target, model_target(bus.fetch_pc));
      chk("flush", {31'd0, bus.mispredict_flush}, {31'd0, m_flush});
      chk("redirect", bus.redirect_pc, m_redir);
`ifdef BP_PERF_CNT_EN
      chk("perf_branches", bus.perf_branches, m_pb);
      chk("perf_mispredicts", bus.perf_mispredicts, m_pm);
`else
      chk("perf_branches", bus.perf_branches, 32'd0);
      chk("perf_mispredicts", bus.perf_mispredicts, 32'd0);
`endif
      resolve = bus.ex_valid && bus.ex_is_branch && !m_flush;
      mis = resolve && ((bus.ex_pred_taken != bus.branch_taken) ||
                        (bus.branch_taken && bus.ex_pred_target != bus.branch_target));
      m_flush = mis;
      if (resolve) begin
        m_redir = bus.branch_taken ? bus.branch_target : bus.ex_pc + 32'd4;
        b = int'((bus.ex_pc >> 2) % 64);
        t = int'((bus.ex_pc >> 2) % 16);
        if (bus.branch_taken) begin
          if (m_cnt[b] < 3) m_cnt[b]++;
          m_valid[t] = 1'b1;
          m_tagpc[t] = bus.ex_pc;
          m_tgt[t]   = bus.branch_target;
        end else if (m_cnt[b] > 0) begin
          m_cnt[b]--;
        end
        m_pb = m_pb + 32'd1;
      end
      if (mis) m_pm = m_pm + 32'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve_in(input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                            input logic bt, input logic [31:0] btg);
    bus.ex_valid       = 1'b1;
    bus.ex_is_branch   = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptg;
    bus.branch_taken   = bt;
    bus.branch_target  = btg;
  endtask

  task automatic idle();
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return 32'h1000 + 32'(4 * $urandom_range(0, 7)) + 32'(32'h100 * $urandom_range(0, 3))
           + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] pc;
    logic [31:0] tg;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.fetch_pc = 32'h1000;
    bus.ex_valid = 1'b0;
    bus.ex_is_branch = 1'b0;
    bus.ex_pc = 32'd0;
    bus.ex_pred_taken = 1'b0;
    bus.ex_pred_target = 32'd0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_flush", {31'd0, bus.mispredict_flush}, 32'd0);
    chk("reset_redirect", bus.redirect_pc, 32'd0);
    chk("reset_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    chk("reset_pred_target", bus.pred_target, 32'h1004);

    // Cold taken branch
    resolve_in(32'h1000, 1'b0, 32'h1004, 1'b1, 32'h2000);
    tick(); idle();
    chk("cold_flush", {31'd0, bus.mispredict_flush}, 32'd1);
    chk("cold_redirect", bus.redirect_pc, 32'h2000);
    tick();
    chk("cold_flush_drop", {31'd0, bus.mispredict_flush}, 32'd0);
    chk("cold_pred_taken", {31'd0, bus.pred_taken}, 32'd1);
    chk("cold_pred_target", bus.pred_target, 32'h2000);

    // Saturation then hysteresis
    repeat (4) begin
      resolve_in(32'h1000, 1'b1, 32'h2000, 1'b1, 32'h2000);
      tick();
    end
    resolve_in(32'h1000, 1'b1, 32'h2000, 1'b0, 32'h1234);
    tick(); idle();
    chk("nt1_flush", {31'd0, bus.mispredict_flush}, 32'd1);
    chk("nt1_redirect", bus.redirect_pc, 32'h1004);
    chk("nt1_pred_taken", {31'd0, bus.pred_taken}, 32'd1);
    tick();
    resolve_in(32'h1000, 1'b1, 32'h2000, 1'b0, 32'h1234);
    tick(); idle();
    chk("nt2_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    chk("nt2_pred_target", bus.pred_target, 32'h1004);
    tick();

    // Correct prediction: no flush
    resolve_in(32'h1000, 1'b1, 32'h2000, 1'b1, 32'h2000);
    tick(); idle();
    chk("correct_no_flush", {31'd0, bus.mispredict_flush}, 32'd0);
    tick();

    // Wrong target
    resolve_in(32'h1000, 1'b1, 32'h2000, 1'b1, 32'h3000);
    tick(); idle();
    chk("wrongtgt_flush", {31'd0, bus.mispredict_flush}, 32'd1);
    chk("wrongtgt_redirect", bus.redirect_pc, 32'h3000);
    tick();

    // Flush shadow after a fresh reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    resolve_in(32'h1000, 1'b0, 32'h1004, 1'b1, 32'h2000);
    tick();
    resolve_in(32'h2000, 1'b0, 32'h2004, 1'b1, 32'h5000);
    chk("shadow_flush", {31'd0, bus.mispredict_flush}, 32'd1);
    tick(); idle();
    chk("shadow_single_pulse", {31'd0, bus.mispredict_flush}, 32'd0);
    chk("shadow_redirect", bus.redirect_pc, 32'h2000);
`ifdef BP_PERF_CNT_EN
    chk("shadow_perf_br", bus.perf_branches, 32'd1);
    chk("shadow_perf_mis", bus.perf_mispredicts, 32'd1);
`else
    chk("shadow_perf_br", bus.perf_branches, 32'd0);
    chk("shadow_perf_mis", bus.perf_mispredicts, 32'd0);
`endif
    bus.fetch_pc = 32'h2000;
    #1;
    chk("shadow_no_train", {31'd0, bus.pred_taken}, 32'd0);

    // Asynchronous reset in the middle of a flush pulse
    tick();
    resolve_in(32'h1000, 1'b0, 32'h1004, 1'b1, 32'h2000);
    tick(); idle();
    chk("async_pre_flush", {31'd0, bus.mispredict_flush}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_flush_clear", {31'd0, bus.mispredict_flush}, 32'd0);
    chk("async_redirect_clear", bus.redirect_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.fetch_pc = rand_pc();
      pc = rand_pc();
      tg = 32'h4000 + 32'(4 * $urandom_range(0, 3));
      bus.ex_valid     = ($urandom_range(0, 3) != 0);
      bus.ex_is_branch = ($urandom_range(0, 4) != 0);
      bus.ex_pc        = pc;
      if ($urandom_range(0, 9) < 6) begin
        bus.ex_pred_taken  = model_taken(pc);
        bus.ex_pred_target = model_target(pc);
      end else begin
        bus.ex_pred_taken  = 1'($urandom_range(0, 1));
        bus.ex_pred_target = 32'h4000 + 32'(4 * $urandom_range(0, 3));
      end
      bus.branch_taken  = ($urandom_range(0, 9) < 6);
      bus.branch_target = tg;
      tick();
    end
    idle();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
